// File: rtl/float_discriminant_distributor.sv
// Round-robin dispatcher/collector for a pool of float_discriminant workers; results return in issue order.
// Optional feature macro: FLOAT_DISTRIBUTOR_DROP_CNT_EN adds a saturating drop_cnt output.
`ifndef CVW_FLEN
`define CVW_FLEN 64
`endif

module float_discriminant_distributor #(
  parameter int unsigned N_UNITS = 4,
  localparam int unsigned FLEN = `CVW_FLEN,
  localparam int unsigned PW = $clog2(N_UNITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  input  logic [FLEN-1:0]           a,
  input  logic [FLEN-1:0]           b,
  input  logic [FLEN-1:0]           c,
  output logic                      busy,
  output logic                      res_vld,
  output logic [FLEN-1:0]           res,
  output logic                      res_negative,
  output logic                      err,
`ifdef FLOAT_DISTRIBUTOR_DROP_CNT_EN
  output logic [15:0]               drop_cnt,
`endif
  output logic [N_UNITS-1:0]        w_arg_vld,
  output logic [FLEN-1:0]           w_a,
  output logic [FLEN-1:0]           w_b,
  output logic [FLEN-1:0]           w_c,
  input  logic [N_UNITS-1:0]        w_busy,
  input  logic [N_UNITS-1:0]        w_res_vld,
  input  logic [N_UNITS*FLEN-1:0]   w_res,
  input  logic [N_UNITS-1:0]        w_res_negative,
  input  logic [N_UNITS-1:0]        w_err
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} slot_e;

  slot_e               slot     [N_UNITS];
  logic [FLEN-1:0]     hold_res [N_UNITS];
  logic [N_UNITS-1:0]  hold_neg;
  logic [N_UNITS-1:0]  hold_err;
  logic [PW-1:0]       dp;
  logic [PW-1:0]       cp;
  logic                issue;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(N_UNITS - 1)) ? '0 : p + PW'(1);
  endfunction

  // The next worker in rotation must be both free of our bookkeeping and not self-reporting busy.
  always_comb begin
    busy  = (slot[dp] != S_IDLE) | w_busy[dp];
    issue = arg_vld & ~busy;
  end

  // Slot states never overlap between issue (IDLE), capture (PEND) and collect (DONE),
  // so the three writers below cannot collide on one slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp           <= '0;
      cp           <= '0;
      busy_unused();
      w_arg_vld    <= '0;
      w_a          <= '0;
      w_b          <= '0;
      w_c          <= '0;
      res_vld      <= 1'b0;
      res          <= '0;
      res_negative <= 1'b0;
      err          <= 1'b0;
      hold_neg     <= '0;
      hold_err     <= '0;
      for (int unsigned i = 0; i < N_UNITS; i++) begin
        slot[i]     <= S_IDLE;
        hold_res[i] <= '0;
      end
    end else begin
      w_arg_vld <= '0;
      res_vld   <= 1'b0;

      for (int unsigned i = 0; i < N_UNITS; i++) begin
        if (w_res_vld[i] && slot[i] == S_PEND) begin
          slot[i]     <= S_DONE;
          hold_res[i] <= w_res[i*FLEN +: FLEN];
          hold_neg[i] <= w_res_negative[i];
          hold_err[i] <= w_err[i];
        end
      end

      if (issue) begin
        w_arg_vld <= N_UNITS'(1) << dp;
        w_a       <= a;
        w_b       <= b;
        w_c       <= c;
        slot[dp]  <= S_PEND;
        dp        <= wrap_inc(dp);
      end

      if (slot[cp] == S_DONE) begin
        res_vld      <= 1'b1;
        res          <= hold_res[cp];
        res_negative <= hold_neg[cp];
        err          <= hold_err[cp];
        slot[cp]     <= S_IDLE;
        cp           <= wrap_inc(cp);
      end
    end
  end

  task automatic busy_unused();
  endtask

`ifdef FLOAT_DISTRIBUTOR_DROP_CNT_EN
  // Cycles where upstream presented an operand set that could not be taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (arg_vld && busy && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_float_discriminant_distributor.sv
// Randomized self-checking bench for float_discriminant_distributor with behavioural worker models.
module tb_float_discriminant_distributor;

  localparam int unsigned N  = 4;
  localparam int unsigned FL = 64;
  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] THREE = 64'h4008000000000000;
  localparam logic [63:0] PINF  = 64'h7FF0000000000000;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [31:0] unit;
  } iss_t;

  typedef struct packed {
    logic [63:0] res;
    logic        neg;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arg_vld = 1'b0;
  logic [FL-1:0]     a = '0;
  logic [FL-1:0]     b = '0;
  logic [FL-1:0]     c = '0;
  logic              busy;
  logic              res_vld;
  logic [FL-1:0]     res;
  logic              res_negative;
  logic              err;
  logic [N-1:0]      w_arg_vld;
  logic [FL-1:0]     w_a;
  logic [FL-1:0]     w_b;
  logic [FL-1:0]     w_c;
  logic [N-1:0]      w_busy;
  logic [N-1:0]      w_res_vld = '0;
  logic [N*FL-1:0]   w_res = '0;
  logic [N-1:0]      w_res_negative = '0;
  logic [N-1:0]      w_err = '0;
`ifdef FLOAT_DISTRIBUTOR_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  float_discriminant_distributor #(.N_UNITS(N)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .busy(busy), .res_vld(res_vld), .res(res), .res_negative(res_negative), .err(err),
`ifdef FLOAT_DISTRIBUTOR_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .w_arg_vld(w_arg_vld), .w_a(w_a), .w_b(w_b), .w_c(w_c),
    .w_busy(w_busy), .w_res_vld(w_res_vld), .w_res(w_res),
    .w_res_negative(w_res_negative), .w_err(w_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_res    = 0;
  int exp_unit = 0;
  iss_t iq[$];
  exp_t eq[$];
  logic [63:0] last_res = '0;
  logic        last_neg = 1'b0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Discriminant b*b - 4ac in real arithmetic; err flags any Inf/NaN operand or result.
  function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] ic);
    real  ra, rb, rc, d;
    exp_t e;
    ra = $bitstoreal(ia);
    rb = $bitstoreal(ib);
    rc = $bitstoreal(ic);
    d  = rb * rb - 4.0 * ra * rc;
    e.res = $realtobits(d);
    e.neg = (d < 0.0);
    e.err = (ia[62:52] == 11'h7FF) | (ib[62:52] == 11'h7FF) | (ic[62:52] == 11'h7FF) |
            (e.res[62:52] == 11'h7FF);
    return e;
  endfunction

  // Worker models: fixed per-worker latency, busy while computing, one-cycle result strobe.
  int          lat    [N] = '{default: 3};
  int          remain [N] = '{default: 0};
  exp_t        pend   [N];
  logic [N-1:0] force_busy = '0;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < N; i++) w_busy[i] = (remain[i] != 0) | force_busy[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      w_res_vld[i] <= 1'b0;
      if (w_arg_vld[i]) begin
        remain[i] <= lat[i];
        pend[i]   <= model(w_a, w_b, w_c);
      end else if (remain[i] != 0) begin
        remain[i] <= remain[i] - 1;
        if (remain[i] == 1) begin
          w_res_vld[i]         <= 1'b1;
          w_res[i*FL +: FL]    <= pend[i].res;
          w_res_negative[i]    <= pend[i].neg;
          w_err[i]             <= pend[i].err;
        end
      end
    end
  end

  // Scoreboard: issue strobes against accepted beats, results against issue order.
  iss_t mi;
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      if (w_arg_vld != '0) begin
        if (iq.size() == 0) begin
          check("w_arg_unexpected", 64'(w_arg_vld), 64'd0);
        end else begin
          mi = iq.pop_front();
          check("w_arg_vld", 64'(w_arg_vld), 64'd1 << mi.unit);
          check("w_a", w_a, mi.a);
          check("w_b", w_b, mi.b);
          check("w_c", w_c, mi.c);
        end
      end
      if (res_vld) begin
        n_res++;
        last_res = res;
        last_neg = res_negative;
        last_err = err;
        if (eq.size() == 0) begin
          check("res_unexpected", 64'd1, 64'd0);
        end else begin
          me = eq.pop_front();
          check("res", res, me.res);
          check("res_negative", 64'(res_negative), 64'(me.neg));
          check("err", 64'(err), 64'(me.err));
        end
      end
    end
  end

  // Presents one beat, holding arg_vld until accepted; returns stall cycles and res_vld at acceptance.
  task automatic send(input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] ic,
                      output int stalls, output logic rv_at_accept);
    arg_vld = 1'b1;
    a = ia;
    b = ib;
    c = ic;
    stalls = 0;
    rv_at_accept = 1'b0;
    while (busy && stalls < 300) begin
      @(negedge clk);
      stalls++;
    end
    if (busy) begin
      check("send_timeout", 64'(stalls), 64'd0);
      arg_vld = 1'b0;
      return;
    end
    rv_at_accept = res_vld;
    iq.push_back('{a: ia, b: ib, c: ic, unit: 32'(exp_unit)});
    eq.push_back(model(ia, ib, ic));
    exp_unit = (exp_unit + 1) % N;
    @(negedge clk);
    arg_vld = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (eq.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain_results", 64'(eq.size()), 64'd0);
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iq.delete();
    eq.delete();
    exp_unit = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd_op();
    if ($urandom_range(0, 15) == 0) return PINF;
    return $realtobits(real'(int'($urandom_range(0, 40)) - 20) / 4.0);
  endfunction

  initial begin
    int   st, sum, k, n0, acc;
    logic rv;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_res_vld", 64'(res_vld), 64'd0);
    check("rst_w_arg_vld", 64'(w_arg_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res", res, 64'd0);
    check("rst_w_a", w_a, 64'd0);
    check("rst_flags", {62'd0, res_negative, err}, 64'd0);

    // Single beat, latency to result strobe.
    send(ONE, THREE, ONE, st, rv);
    check("t1_w_arg_vld", 64'(w_arg_vld), 64'd1);
    k = 0;
    while (!w_res_vld[0] && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("t1_worker_answered", 64'(w_res_vld[0]), 64'd1);
    @(negedge clk);
    check("t1_res_vld_plus1", 64'(res_vld), 64'd0);
    @(negedge clk);
    check("t1_res_vld_plus2", 64'(res_vld), 64'd1);
    check("t1_res", res, 64'h4014000000000000);
    check("t1_neg_err", {62'd0, res_negative, err}, 64'd0);
    drain();

    // Back-to-back beats rotate over all workers.
    sum = 0;
    n0 = n_res;
    for (int i = 0; i < 8; i++) begin
      send(rnd_op(), rnd_op(), rnd_op(), st, rv);
      if (i < 4) sum += st;
    end
    check("t2_no_stall_first_round", 64'(sum), 64'd0);
    drain();
    check("t2_result_count", 64'(n_res - n0), 64'd8);

    // Slow worker 0 holds back faster finishers; fifth beat waits for result 0.
    lat = '{9, 2, 2, 2};
    for (int i = 0; i < 4; i++) send(rnd_op(), rnd_op(), rnd_op(), st, rv);
    send(ONE, THREE, ONE, st, rv);
    check("t3_beat5_stalled", 64'(st != 0), 64'd1);
    check("t3_beat5_unblock_with_res0", 64'(rv), 64'd1);
    drain();

    // Negative discriminant and error pass-through.
    lat = '{3, 3, 3, 3};
    send(ONE, ONE, ONE, st, rv);
    drain();
    check("t4_res", last_res, 64'hC008000000000000);
    check("t4_neg", 64'(last_neg), 64'd1);
    send(PINF, ONE, ONE, st, rv);
    drain();
    check("t4_err", 64'(last_err), 64'd1);

    // Reset with work in flight discards it.
    lat = '{6, 6, 6, 6};
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), rnd_op(), st, rv);
    @(negedge clk);
    do_reset();
    n0 = n_res;
    repeat (25) @(negedge clk);
    check("t5_no_res_after_rst", 64'(n_res - n0), 64'd0);
    lat = '{3, 3, 3, 3};
    send(ONE, THREE, ONE, st, rv);
    check("t5_next_to_worker0", 64'(w_arg_vld), 64'd1);
    drain();

`ifdef FLOAT_DISTRIBUTOR_DROP_CNT_EN
    do_reset();
    check("t6_drop_cnt_rst", 64'(drop_cnt), 64'd0);
    force_busy = 4'b0001;
    arg_vld = 1'b1;
    a = ONE;
    b = ONE;
    c = ONE;
    repeat (5) @(negedge clk);
    arg_vld = 1'b0;
    check("t6_drop_cnt", 64'(drop_cnt), 64'd5);
    force_busy = '0;
    repeat (4) @(negedge clk);
`endif

    // Random traffic with random worker latencies and gaps.
    n0 = n_res;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < N; j++) lat[j] = int'($urandom_range(1, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rnd_op(), rnd_op(), rnd_op(), st, rv);
      acc++;
    end
    drain();
    check("rand_result_count", 64'(n_res - n0), 64'(acc));
    check("rand_issue_queue_empty", 64'(iq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
